axi4_stream_initiator_type_1: RTL and testbench
===============================================

# axi4_stream_initiator_type_1

Simple traffic source for AXI4-Stream transfers, the transmit-side counterpart of the type-1 stream target in the simulation traffic library. It generates a deterministic stream of frames, packets and transfers with an incrementing tdata pattern, fixed tdest, per-stream tid and configurable tlast placement. It can optionally throttle tvalid into active and pause windows. Testbench use only; its parameters mirror the target's so that a paired target drains exactly what this block emits.

## Interface
- AxiStreamInitiatorIfTDataWidth, 32: tdata width in bits.
- AxiStreamInitiatorIfTIdWidth, 4: tid width.
- AxiStreamInitiatorIfTDestWidth, 4: tdest width.
- AxiStreamInitiatorIfTId, 0: tid of the first stream.
- AxiStreamInitiatorIfTDest, 0: constant tdest.
- AxiStreamInitiatorIfInitiatorMode, "LOOP": "SINGLE" emits one stream then stops; "LOOP" repeats streams forever.
- AxiStreamInitiatorIfCyclesActive, 0: length of the tvalid active window, in cycles.
- AxiStreamInitiatorIfCyclesPause, 0: pause length in cycles; 0 disables throttling.
- AxiStreamInitiatorIfTransfersPerPacket / PacketsPerFrame / FramesPerStream, 1 / 1 / 1: stream geometry; 0 is treated as 1.
- AxiStreamInitiatorIfTlastFlagTrigger, "NONE": "NONE", "TRANSFER", "PACKET", "FRAME" or "STREAM".

Ports:
- clk_m_axis_i  in  1  clock; all logic on the rising edge.
- rst_m_axis_ni  in  1  reset; asynchronous, active-low.
- m_axis_tvalid_o  out  1  transfer valid.
- m_axis_tready_i  in  1  downstream ready.
- m_axis_tdata_o  out  TDataWidth  payload.
- m_axis_tlast_o  out  1  boundary flag.
- m_axis_tid_o  out  TIdWidth  stream id.
- m_axis_tdest_o  out  TDestWidth  destination.
- m_axis_tdone_o  out  1  SINGLE mode: high after the final transfer is accepted.

## Operation
- A handshake is a cycle with tvalid=1 and tready=1. All counters and the data pattern advance only on a handshake.
- Initial tdata and increment depend on width:
  - width ≤8: A0 / 01.
  - width ≤16: 0A00 / 0101.
  - otherwise: ABC00B00 / 00010001, truncated or zero-extended to the width.
  - tdata adds the increment modulo 2^W per handshake and is never reloaded in LOOP mode.
- Counters hold "remaining minus one": transfer (T), packet (P) and frame (F), loaded with param-1.
  - On a handshake with T>0: decrement T.
  - Otherwise reload T and decrement P; when P is also 0, reload P and decrement F.
  - When F is also 0 (end of stream): reload F.
- tlast is combinational from the counters:
  - NONE: 0.
  - TRANSFER: 1.
  - PACKET: T==0.
  - FRAME: T==0 && P==0.
  - STREAM: T==P==F==0.
- End of stream in SINGLE mode sets done; tvalid is 0 thereafter until reset.
- Throttling applies only when CyclesPause>0.
  - States: ACTIVE and PAUSE.
  - In ACTIVE, tvalid=1 (unless done), and the active counter (loaded with CyclesActive) decrements each cycle tvalid=1.
  - When the counter reaches 0, go to PAUSE, but only in a cycle with a handshake or with tvalid=0.
  - Once raised, tvalid never drops before its handshake (AXI rule); the counter saturates at 0 while waiting.
  - In PAUSE, tvalid=0 for CyclesPause cycles, then return to ACTIVE with the counter reloaded.
  - CyclesActive=0 with CyclesPause>0 is treated as 1.
- While tvalid=1 and tready=0, tdata, tlast, tid and tdest are held stable.

## Timing
- Reset values:
  - tvalid=0, tdone=0.
  - tdata=initial value, tid=AxiStreamInitiatorIfTId, tdest=AxiStreamInitiatorIfTDest.
  - tlast=trigger evaluated on loaded counters, e.g. 1 for TRANSFER, or for PACKET when TransfersPerPacket≤1.
  - Counters loaded; state ACTIVE.
- tvalid is registered: it first rises on the first clock edge after reset deasserts.
- No bubbles without throttling: with tready tied high, one transfer per cycle.
- Reset asserted mid-stream returns every output to its reset value immediately (asynchronously), regardless of a pending handshake.
- Simultaneous events: an end-of-stream handshake in the same cycle as the active-counter expiry performs both the counter reload and the PAUSE entry.
- tdone rises on the edge after the final handshake, in the same edge that drops tvalid.

## Configuration
- AXI4_STREAM_INITIATOR_TYPE_1_TID_INCR_EN:
  - Defined: tid increments by 1 (modulo 2^TIdWidth) on every end-of-stream handshake in LOOP mode. This matches the type-1 target.
  - Undefined: tid is constant at AxiStreamInitiatorIfTId.
  - SINGLE mode is unaffected.

## Test plan
- Geometry 2/2/2, trigger PACKET, SINGLE, tready=1, width 32 → 8 transfers ABC00B00, ABC10B01, … ABC70B07; tlast on transfers 2, 4, 6 and 8; tdone=1 one cycle after the 8th; tvalid stays 0.
- Same geometry, trigger STREAM, tready random 50% → tdata, tlast and tid stable during every stall; tlast only on the 8th transfer; no tvalid drop before a handshake.
- LOOP, TID_INCR_EN defined, tid start 3, geometry 1/1/2 → tid is 3,3 then 4,4 then 5,5; tdata keeps incrementing across streams.
- CyclesActive=3, CyclesPause=2, tready=1 → tvalid pattern 1,1,1,0,0,1,1,1,0,0…
- Throttling with tready=0 at window end → tvalid held until tready=1 arrives, then exactly 2 idle cycles.
- Reset asserted after 3 transfers, then released → outputs return to reset values asynchronously; the stream restarts at tdata ABC00B00 with tid at its initial value.

Source files
------------

// File: rtl/axi4_stream_initiator_type_1.sv
// Deterministic AXI4-Stream traffic source with tlast placement and optional tvalid throttling.
// Optional feature: define AXI4_STREAM_INITIATOR_TYPE_1_TID_INCR_EN to step tid per stream in LOOP mode.
module axi4_stream_initiator_type_1 #(
  parameter int    AxiStreamInitiatorIfTDataWidth         = 32,
  parameter int    AxiStreamInitiatorIfTIdWidth           = 4,
  parameter int    AxiStreamInitiatorIfTDestWidth         = 4,
  parameter int    AxiStreamInitiatorIfTId                = 0,
  parameter int    AxiStreamInitiatorIfTDest              = 0,
  parameter string AxiStreamInitiatorIfInitiatorMode      = "LOOP",
  parameter int    AxiStreamInitiatorIfCyclesActive       = 0,
  parameter int    AxiStreamInitiatorIfCyclesPause        = 0,
  parameter int    AxiStreamInitiatorIfTransfersPerPacket = 1,
  parameter int    AxiStreamInitiatorIfPacketsPerFrame    = 1,
  parameter int    AxiStreamInitiatorIfFramesPerStream    = 1,
  parameter string AxiStreamInitiatorIfTlastFlagTrigger   = "NONE"
) (
  input  logic                                      clk_m_axis_i,
  input  logic                                      rst_m_axis_ni,
  output logic                                      m_axis_tvalid_o,
  input  logic                                      m_axis_tready_i,
  output logic [AxiStreamInitiatorIfTDataWidth-1:0] m_axis_tdata_o,
  output logic                                      m_axis_tlast_o,
  output logic [AxiStreamInitiatorIfTIdWidth-1:0]   m_axis_tid_o,
  output logic [AxiStreamInitiatorIfTDestWidth-1:0] m_axis_tdest_o,
  output logic                                      m_axis_tdone_o
);

  localparam int DW = AxiStreamInitiatorIfTDataWidth;
  localparam int IW = AxiStreamInitiatorIfTIdWidth;

  localparam logic [DW-1:0] DataInit = (DW <= 8)  ? DW'(8'hA0) :
                                       (DW <= 16) ? DW'(16'h0A00) : DW'(32'hABC00B00);
  localparam logic [DW-1:0] DataIncr = (DW <= 8)  ? DW'(8'h01) :
                                       (DW <= 16) ? DW'(16'h0101) : DW'(32'h00010001);

  // Counters hold "remaining minus one"; a zero geometry parameter behaves as one.
  localparam logic [31:0] TLoad = (AxiStreamInitiatorIfTransfersPerPacket < 2) ? 32'd0 :
                                  32'(AxiStreamInitiatorIfTransfersPerPacket - 1);
  localparam logic [31:0] PLoad = (AxiStreamInitiatorIfPacketsPerFrame < 2) ? 32'd0 :
                                  32'(AxiStreamInitiatorIfPacketsPerFrame - 1);
  localparam logic [31:0] FLoad = (AxiStreamInitiatorIfFramesPerStream < 2) ? 32'd0 :
                                  32'(AxiStreamInitiatorIfFramesPerStream - 1);

  localparam bit          ThrottleEn = (AxiStreamInitiatorIfCyclesPause > 0);
  localparam logic [31:0] ActLoad    = (AxiStreamInitiatorIfCyclesActive < 1) ? 32'd1 :
                                       32'(AxiStreamInitiatorIfCyclesActive);
  localparam logic [31:0] PauseLoad  = ThrottleEn ? 32'(AxiStreamInitiatorIfCyclesPause) : 32'd0;
  localparam bit          SingleMode = (AxiStreamInitiatorIfInitiatorMode == "SINGLE");

  typedef enum logic [2:0] {
    TRIG_NONE, TRIG_TRANSFER, TRIG_PACKET, TRIG_FRAME, TRIG_STREAM
  } trig_e;

  localparam trig_e Trig = (AxiStreamInitiatorIfTlastFlagTrigger == "TRANSFER") ? TRIG_TRANSFER :
                           (AxiStreamInitiatorIfTlastFlagTrigger == "PACKET")   ? TRIG_PACKET :
                           (AxiStreamInitiatorIfTlastFlagTrigger == "FRAME")    ? TRIG_FRAME :
                           (AxiStreamInitiatorIfTlastFlagTrigger == "STREAM")   ? TRIG_STREAM :
                                                                                  TRIG_NONE;

  typedef enum logic {ST_ACTIVE, ST_PAUSE} state_e;

  state_e          state_q, state_d;
  logic            tvalid_q, tvalid_d;
  logic            done_q, done_d;
  logic [DW-1:0]   tdata_q, tdata_d;
  logic [IW-1:0]   tid_q, tid_d;
  logic [31:0]     t_q, t_d, p_q, p_d, f_q, f_d;
  logic [31:0]     act_q, act_d, pause_q, pause_d;
  logic            hs, eos;

  assign hs  = tvalid_q & m_axis_tready_i;
  assign eos = hs & (t_q == 32'd0) & (p_q == 32'd0) & (f_q == 32'd0);

  // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    tdata_d  = tdata_q;
    tid_d    = tid_q;
    t_d      = t_q;
    p_d      = p_q;
    f_d      = f_q;
    act_d    = act_q;
    pause_d  = pause_q;
    tvalid_d = tvalid_q;

    if (hs) begin
      tdata_d = tdata_q + DataIncr;
      if (t_q != 32'd0) begin
        t_d = t_q - 32'd1;
      end else begin
        t_d = TLoad;
        if (p_q != 32'd0) begin
          p_d = p_q - 32'd1;
        end else begin
          p_d = PLoad;
          f_d = (f_q != 32'd0) ? f_q - 32'd1 : FLoad;
        end
      end
    end

    done_d = done_q | (SingleMode & eos);

`ifdef AXI4_STREAM_INITIATOR_TYPE_1_TID_INCR_EN
    if (!SingleMode && eos) tid_d = tid_q + 1'b1;
`endif

    if (!ThrottleEn) begin
      tvalid_d = ~done_d;
    end else begin
      case (state_q)
        ST_ACTIVE: begin
          if (tvalid_q && act_q != 32'd0) act_d = act_q - 32'd1;
          // Window expiry may only end the beat once it has been accepted (or was never offered).
          if ((hs || !tvalid_q) && act_d == 32'd0) begin
            state_d  = ST_PAUSE;
            pause_d  = PauseLoad;
            tvalid_d = 1'b0;
          end else begin
            tvalid_d = ~done_d;
          end
        end
        ST_PAUSE: begin
          tvalid_d = 1'b0;
          if (pause_q <= 32'd1) begin
            state_d  = ST_ACTIVE;
            act_d    = ActLoad;
            tvalid_d = ~done_q;
          end else begin
            pause_d = pause_q - 32'd1;
          end
        end
        default: state_d = ST_ACTIVE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_m_axis_i or negedge rst_m_axis_ni) begin
    if (!rst_m_axis_ni) begin
      state_q  <= ST_ACTIVE;
      tvalid_q <= 1'b0;
      done_q   <= 1'b0;
      tdata_q  <= DataInit;
      tid_q    <= IW'(AxiStreamInitiatorIfTId);
      t_q      <= TLoad;
      p_q      <= PLoad;
      f_q      <= FLoad;
      act_q    <= ActLoad;
      pause_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      tvalid_q <= tvalid_d;
      done_q   <= done_d;
      tdata_q  <= tdata_d;
      tid_q    <= tid_d;
      t_q      <= t_d;
      p_q      <= p_d;
      f_q      <= f_d;
      act_q    <= act_d;
      pause_q  <= pause_d;
    end
  end

  always_comb begin
    m_axis_tlast_o = 1'b0;
    case (Trig)
      TRIG_TRANSFER: m_axis_tlast_o = 1'b1;
      TRIG_PACKET:   m_axis_tlast_o = (t_q == 32'd0);
      TRIG_FRAME:    m_axis_tlast_o = (t_q == 32'd0) && (p_q == 32'd0);
      TRIG_STREAM:   m_axis_tlast_o = (t_q == 32'd0) && (p_q == 32'd0) && (f_q == 32'd0);
      default:       m_axis_tlast_o = 1'b0;
    endcase
  end

  assign m_axis_tvalid_o = tvalid_q;
  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tid_o    = tid_q;
  assign m_axis_tdest_o  = AxiStreamInitiatorIfTDestWidth'(AxiStreamInitiatorIfTDest);
  assign m_axis_tdone_o  = done_q;

endmodule

// File: tb/tb_axi4_stream_initiator_type_1.sv
// Self-checking bench: several initiator configurations share one clock and reset and are
// exercised phase by phase against tables and an arithmetic stream model.
module tb_axi4_stream_initiator_type_1;

`ifdef AXI4_STREAM_INITIATOR_TYPE_1_TID_INCR_EN
  localparam bit TidIncr = 1'b1;
`else
  localparam bit TidIncr = 1'b0;
`endif

  localparam int TR_NONE = 0, TR_TRANSFER = 1, TR_PACKET = 2, TR_FRAME = 3, TR_STREAM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld [6];
  logic        rdy [6];
  logic        lst [6];
  logic        dn  [6];
  logic [3:0]  tid [6];
  logic [3:0]  dst [6];
  logic [31:0] dat [4];
  logic [15:0] dat4;
  logic [7:0]  dat5;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // u0: 2/2/2 PACKET SINGLE, tdest 5
  axi4_stream_initiator_type_1 #(
    .AxiStreamInitiatorIfTDest(5), .AxiStreamInitiatorIfInitiatorMode("SINGLE"),
    .AxiStreamInitiatorIfTransfersPerPacket(2), .AxiStreamInitiatorIfPacketsPerFrame(2),
    .AxiStreamInitiatorIfFramesPerStream(2), .AxiStreamInitiatorIfTlastFlagTrigger("PACKET")
  ) u0 (
    .clk_m_axis_i(clk), .rst_m_axis_ni(rst_n), .m_axis_tvalid_o(vld[0]), .m_axis_tready_i(rdy[0]),
    .m_axis_tdata_o(dat[0]), .m_axis_tlast_o(lst[0]), .m_axis_tid_o(tid[0]),
    .m_axis_tdest_o(dst[0]), .m_axis_tdone_o(dn[0]));

  // u1: 2/2/2 STREAM LOOP, tid 3, random tready
  axi4_stream_initiator_type_1 #(
    .AxiStreamInitiatorIfTId(3), .AxiStreamInitiatorIfInitiatorMode("LOOP"),
    .AxiStreamInitiatorIfTransfersPerPacket(2), .AxiStreamInitiatorIfPacketsPerFrame(2),
    .AxiStreamInitiatorIfFramesPerStream(2), .AxiStreamInitiatorIfTlastFlagTrigger("STREAM")
  ) u1 (
    .clk_m_axis_i(clk), .rst_m_axis_ni(rst_n), .m_axis_tvalid_o(vld[1]), .m_axis_tready_i(rdy[1]),
    .m_axis_tdata_o(dat[1]), .m_axis_tlast_o(lst[1]), .m_axis_tid_o(tid[1]),
    .m_axis_tdest_o(dst[1]), .m_axis_tdone_o(dn[1]));

  // u2: 1/1/2 STREAM LOOP, tid 3
  axi4_stream_initiator_type_1 #(
    .AxiStreamInitiatorIfTId(3), .AxiStreamInitiatorIfInitiatorMode("LOOP"),
    .AxiStreamInitiatorIfTransfersPerPacket(1), .AxiStreamInitiatorIfPacketsPerFrame(1),
    .AxiStreamInitiatorIfFramesPerStream(2), .AxiStreamInitiatorIfTlastFlagTrigger("STREAM")
  ) u2 (
    .clk_m_axis_i(clk), .rst_m_axis_ni(rst_n), .m_axis_tvalid_o(vld[2]), .m_axis_tready_i(rdy[2]),
    .m_axis_tdata_o(dat[2]), .m_axis_tlast_o(lst[2]), .m_axis_tid_o(tid[2]),
    .m_axis_tdest_o(dst[2]), .m_axis_tdone_o(dn[2]));

  // u3: throttled 3 active / 2 pause, TRANSFER trigger
  axi4_stream_initiator_type_1 #(
    .AxiStreamInitiatorIfInitiatorMode("LOOP"), .AxiStreamInitiatorIfCyclesActive(3),
    .AxiStreamInitiatorIfCyclesPause(2), .AxiStreamInitiatorIfTlastFlagTrigger("TRANSFER")
  ) u3 (
    .clk_m_axis_i(clk), .rst_m_axis_ni(rst_n), .m_axis_tvalid_o(vld[3]), .m_axis_tready_i(rdy[3]),
    .m_axis_tdata_o(dat[3]), .m_axis_tlast_o(lst[3]), .m_axis_tid_o(tid[3]),
    .m_axis_tdest_o(dst[3]), .m_axis_tdone_o(dn[3]));

  // u4: 16-bit, zero geometry (acts as 1/1/1), PACKET SINGLE
  axi4_stream_initiator_type_1 #(
    .AxiStreamInitiatorIfTDataWidth(16), .AxiStreamInitiatorIfInitiatorMode("SINGLE"),
    .AxiStreamInitiatorIfTransfersPerPacket(0), .AxiStreamInitiatorIfPacketsPerFrame(0),
    .AxiStreamInitiatorIfFramesPerStream(0), .AxiStreamInitiatorIfTlastFlagTrigger("PACKET")
  ) u4 (
    .clk_m_axis_i(clk), .rst_m_axis_ni(rst_n), .m_axis_tvalid_o(vld[4]), .m_axis_tready_i(rdy[4]),
    .m_axis_tdata_o(dat4), .m_axis_tlast_o(lst[4]), .m_axis_tid_o(tid[4]),
    .m_axis_tdest_o(dst[4]), .m_axis_tdone_o(dn[4]));

  // u5: 8-bit, NONE trigger, LOOP
  axi4_stream_initiator_type_1 #(
    .AxiStreamInitiatorIfTDataWidth(8), .AxiStreamInitiatorIfTlastFlagTrigger("NONE")
  ) u5 (
    .clk_m_axis_i(clk), .rst_m_axis_ni(rst_n), .m_axis_tvalid_o(vld[5]), .m_axis_tready_i(rdy[5]),
    .m_axis_tdata_o(dat5), .m_axis_tlast_o(lst[5]), .m_axis_tid_o(tid[5]),
    .m_axis_tdest_o(dst[5]), .m_axis_tdone_o(dn[5]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected beat n of a stream, from position arithmetic within stream/frame/packet.
  function automatic void model(input int n, input int tpp, input int ppf, input int fps,
                                input int trig, input int tid0,
                                output logic [31:0] d, output logic l, output logic [3:0] id);
    int t, p, f, per, k;
    t   = (tpp < 1) ? 1 : tpp;
    p   = (ppf < 1) ? 1 : ppf;
    f   = (fps < 1) ? 1 : fps;
    per = t * p * f;
    k   = n % per;
    d   = 32'hABC00B00 + 32'(n) * 32'h00010001;
    case (trig)
      TR_TRANSFER: l = 1'b1;
      TR_PACKET:   l = (k % t) == (t - 1);
      TR_FRAME:    l = (k % (t * p)) == (t * p - 1);
      TR_STREAM:   l = (k == per - 1);
      default:     l = 1'b0;
    endcase
    id = 4'(tid0 + (TidIncr ? (n / per) : 0));
  endfunction

  task automatic do_reset();
    for (int i = 0; i < 6; i++) rdy[i] = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Unthrottled instance against the model; expects no bubbles after the first edge.
  task automatic run_model(input int u, input int cycles, input int tpp, input int ppf,
                           input int fps, input int trig, input int tid0, input bit rnd,
                           input string tag);
    int n;
    logic [31:0] ed;
    logic        el;
    logic [3:0]  eid;
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      check({tag, "_valid"}, 64'(vld[u]), 64'(c > 0));
      check({tag, "_done"}, 64'(dn[u]), 64'd0);
      if (vld[u]) begin
        model(n, tpp, ppf, fps, trig, tid0, ed, el, eid);
        check({tag, "_data"}, 64'(dat[u]), 64'(ed));
        check({tag, "_last"}, 64'(lst[u]), 64'(el));
        check({tag, "_tid"}, 64'(tid[u]), 64'(eid));
      end
      rdy[u] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (vld[u] && rdy[u]) n++;
      @(negedge clk);
    end
    rdy[u] = 1'b0;
  endtask

  typedef struct {
    logic        tready;
    logic        valid;
    logic [31:0] data;
    logic        last;
    logic        done;
  } vec_t;

  typedef struct {
    logic tready;
    logic valid;
  } thr_t;

  vec_t        va [11];
  thr_t        vt [12];
  int          n;
  logic [31:0] ed;
  logic        el;
  logic [3:0]  eid;

  initial begin
    va[0]  = '{1'b1, 1'b0, 32'hABC00B00, 1'b0, 1'b0};
    va[1]  = '{1'b1, 1'b1, 32'hABC00B00, 1'b0, 1'b0};
    va[2]  = '{1'b1, 1'b1, 32'hABC10B01, 1'b1, 1'b0};
    va[3]  = '{1'b1, 1'b1, 32'hABC20B02, 1'b0, 1'b0};
    va[4]  = '{1'b1, 1'b1, 32'hABC30B03, 1'b1, 1'b0};
    va[5]  = '{1'b1, 1'b1, 32'hABC40B04, 1'b0, 1'b0};
    va[6]  = '{1'b1, 1'b1, 32'hABC50B05, 1'b1, 1'b0};
    va[7]  = '{1'b1, 1'b1, 32'hABC60B06, 1'b0, 1'b0};
    va[8]  = '{1'b1, 1'b1, 32'hABC70B07, 1'b1, 1'b0};
    va[9]  = '{1'b1, 1'b0, 32'hABC80B08, 1'b0, 1'b1};
    va[10] = '{1'b1, 1'b0, 32'hABC80B08, 1'b0, 1'b1};

    // Stall at the window end: tvalid held until accepted, then two idle cycles.
    vt[0]  = '{1'b1, 1'b0};
    vt[1]  = '{1'b1, 1'b1};
    vt[2]  = '{1'b1, 1'b1};
    vt[3]  = '{1'b0, 1'b1};
    vt[4]  = '{1'b0, 1'b1};
    vt[5]  = '{1'b0, 1'b1};
    vt[6]  = '{1'b0, 1'b1};
    vt[7]  = '{1'b1, 1'b1};
    vt[8]  = '{1'b1, 1'b0};
    vt[9]  = '{1'b1, 1'b0};
    vt[10] = '{1'b1, 1'b1};
    vt[11] = '{1'b1, 1'b1};

    // SINGLE stream, PACKET tlast, tready high
    do_reset();
    check("a_tdest", 64'(dst[0]), 64'd5);
    check("a_tid", 64'(tid[0]), 64'd0);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("a_valid[%0d]", i), 64'(vld[0]), 64'(va[i].valid));
      check($sformatf("a_data[%0d]", i), 64'(dat[0]), 64'(va[i].data));
      check($sformatf("a_last[%0d]", i), 64'(lst[0]), 64'(va[i].last));
      check($sformatf("a_done[%0d]", i), 64'(dn[0]), 64'(va[i].done));
      rdy[0] = va[i].tready;
      @(negedge clk);
    end

    // Random backpressure on a looping STREAM-tlast source
    do_reset();
    run_model(1, 400, 2, 2, 2, TR_STREAM, 3, 1'b1, "b");

    // Loop with tid stepping per stream, tready high
    do_reset();
    run_model(2, 12, 1, 1, 2, TR_STREAM, 3, 1'b0, "c");

    // Throttle pattern with tready high
    do_reset();
    n = 0;
    rdy[3] = 1'b1;
    for (int c = 0; c < 21; c++) begin
      check($sformatf("d_valid[%0d]", c), 64'(vld[3]), 64'((c >= 1) && (((c - 1) % 5) < 3)));
      if (vld[3]) begin
        model(n, 1, 1, 1, TR_TRANSFER, 0, ed, el, eid);
        check("d_data", 64'(dat[3]), 64'(ed));
        check("d_last", 64'(lst[3]), 64'(el));
        n++;
      end
      @(negedge clk);
    end

    do_reset();
    n = 0;
    for (int c = 0; c < 12; c++) begin
      check($sformatf("e_valid[%0d]", c), 64'(vld[3]), 64'(vt[c].valid));
      if (vld[3]) begin
        model(n, 1, 1, 1, TR_TRANSFER, 0, ed, el, eid);
        check($sformatf("e_data[%0d]", c), 64'(dat[3]), 64'(ed));
      end
      rdy[3] = vt[c].tready;
      if (vld[3] && rdy[3]) n++;
      @(negedge clk);
    end

    // Asynchronous reset after three transfers, then restart
    do_reset();
    rdy[2] = 1'b1;
    repeat (4) @(negedge clk);
    model(3, 1, 1, 2, TR_STREAM, 3, ed, el, eid);
    check("f_pre_data", 64'(dat[2]), 64'(ed));
    #2 rst_n = 1'b0;
    #1;
    check("f_rst_valid", 64'(vld[2]), 64'd0);
    check("f_rst_data", 64'(dat[2]), 64'hABC00B00);
    check("f_rst_tid", 64'(tid[2]), 64'd3);
    check("f_rst_last", 64'(lst[2]), 64'd0);
    check("f_rst_done", 64'(dn[2]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy[2] = 1'b0;
    run_model(2, 6, 1, 1, 2, TR_STREAM, 3, 1'b0, "f");

    // Narrow widths and zero geometry
    do_reset();
    check("g_data16_rst", 64'(dat4), 64'h0A00);
    check("g_last16_rst", 64'(lst[4]), 64'd1);
    check("g_data8_rst", 64'(dat5), 64'hA0);
    check("g_last8_rst", 64'(lst[5]), 64'd0);
    rdy[4] = 1'b1;
    rdy[5] = 1'b1;
    @(negedge clk);
    check("g_valid16", 64'(vld[4]), 64'd1);
    check("g_data16", 64'(dat4), 64'h0A00);
    check("g_done16_early", 64'(dn[4]), 64'd0);
    @(negedge clk);
    check("g_valid16_end", 64'(vld[4]), 64'd0);
    check("g_done16", 64'(dn[4]), 64'd1);
    check("g_data16_next", 64'(dat4), 64'h0B01);
    check("g_data8", 64'(dat5), 64'hA1);
    check("g_valid8", 64'(vld[5]), 64'd1);
    @(negedge clk);
    check("g_valid16_stays", 64'(vld[4]), 64'd0);
    check("g_data8_2", 64'(dat5), 64'hA2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
